ifetch_queue: RTL and testbench
===============================

IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, instruction queue entries; power of two, at least 2.
REQ-002 Parameter NOP_INST, default 32'h00000013, value driven on id_inst when the queue is empty.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 pc_i  input  32  fetch address from the PC register.
REQ-006 br_ctrl  input  1  branch/flush; the PC loads a new target next cycle.
REQ-007 pc_stall  output  1  hold request to the PC register; combinational from state and count only.
REQ-008 imem_req  output  1  instruction memory read request; registered.
REQ-009 imem_addr  output  32  read address; registered.
REQ-010 imem_ack  input  1  memory response valid; meaningful only while imem_req=1.
REQ-011 imem_rdata  input  32  instruction word; valid when imem_ack=1.
REQ-012 id_valid  output  1  queue head valid toward decode.
REQ-013 id_ready  input  1  decode accepts the head.
REQ-014 id_inst  output  32  head instruction; NOP_INST when empty.
REQ-015 id_pc  output  32  head instruction address; 0 when empty.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and DROP; at most one memory request is outstanding.
REQ-017 In IDLE, with br_ctrl=0 and count<DEPTH, the block SHALL latch pc_i into imem_addr and go to WAIT.
REQ-018 In IDLE, with br_ctrl=1 or count=DEPTH, the block SHALL stay in IDLE and issue nothing.
REQ-019 pc_stall SHALL be 1 when (state!=IDLE) or (count=DEPTH), and 0 otherwise; the PC advances only on cycles where an address is latched.
REQ-020 imem_req SHALL be 1 exactly while in WAIT or DROP; imem_addr SHALL stay stable until the ack cycle.
REQ-021 In WAIT with imem_ack=1 and br_ctrl=0: push {imem_addr, imem_rdata} at the tail, go to IDLE.
REQ-022 The slot for a push SHALL be guaranteed, because issue needs count<DEPTH and only one request is outstanding.
REQ-023 In WAIT with br_ctrl=1 and imem_ack=0: go to DROP.
REQ-024 In WAIT with br_ctrl=1 and imem_ack=1: discard the data, go to IDLE.
REQ-025 In DROP: keep imem_req=1, discard data on imem_ack, go to IDLE; br_ctrl in DROP SHALL have no additional effect.
REQ-026 Pop SHALL occur when id_valid && id_ready; id_valid = (count!=0).
REQ-027 Push and pop in the same cycle SHALL leave count unchanged and advance both pointers.
REQ-028 br_ctrl=1 SHALL clear count, head and tail next cycle, overriding any push or pop that cycle.
REQ-029 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-030 Entries SHALL leave in program order; the id_pc of each popped entry equals the pc_i latched for it.
REQ-031 Minimum fetch throughput is one instruction per two cycles with a zero-wait memory (ack in the first WAIT cycle).

Reset
REQ-032 With rst=0 at a rising edge: state=IDLE, count=0, head=tail=0, imem_req=0, imem_addr=0.
REQ-033 Consequently, during reset: id_valid=0, id_inst=NOP_INST, id_pc=0, pc_stall=0.
REQ-034 Reset asserted mid-request SHALL abandon it without DROP; any late imem_ack in IDLE SHALL be ignored.
REQ-035 Queue storage contents need not be reset.

Verification
REQ-036 Reset release, pc_i=0,4,8 stepping on pc_stall=0, memory acks in the first WAIT cycle, id_ready=1 -> imem_addr sequence 0,4,8; id_pc 0,4,8 with matching id_inst; pc_stall toggles 0,1.
REQ-037 id_ready=0, continuous fetch -> after 4 pushes count=4, pc_stall stays 1, imem_req=0; one pop reopens issue the next cycle.
REQ-038 br_ctrl=1 while in WAIT with ack delayed 3 cycles -> DROP; imem_req held until ack; data discarded; queue empty; next issue uses the new pc_i (e.g. 0x100).
REQ-039 br_ctrl=1 with imem_ack=1 in the same cycle, queue holding 2 entries -> both entries and the returning word discarded; id_valid=0 next cycle; state IDLE.
REQ-040 Queue at count=1 with simultaneous push and pop -> count stays 1; the new head is the pushed entry; pointers wrap past DEPTH-1 to 0 correctly.
REQ-041 rst=0 asserted in WAIT, ack arriving after rst=1 in IDLE -> the ack is ignored, no push, id_valid=0.

Source files
------------

// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: PC, instruction-memory and decode-side signals of the fetch queue
interface ifetch_queue_if;
  logic [31:0] pc_i;
  logic        br_ctrl;
  logic        pc_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  modport master (
    input  pc_i, br_ctrl, imem_ack, imem_rdata, id_ready,
    output pc_stall, imem_req, imem_addr, id_valid, id_inst, id_pc
  );
  modport slave (
    output pc_i, br_ctrl, imem_ack, imem_rdata, id_ready,
    input  pc_stall, imem_req, imem_addr, id_valid, id_inst, id_pc
  );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: single-outstanding instruction fetcher feeding an in-order decode queue
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input logic            clk,
  input logic            rst,
  ifetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
  state_t        state, state_n;
  logic [CW-1:0] count;
  logic [AW-1:0] head, tail;
  logic [31:0]   pc_mem [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic          full, issue, push, pop;
  assign full         = count == CW'(DEPTH);
  assign issue        = state == IDLE && !bus.br_ctrl && !full;
  assign push         = state == WAIT && bus.imem_ack && !bus.br_ctrl;
  assign pop          = bus.id_valid && bus.id_ready;
  assign bus.pc_stall = state != IDLE || full;
  assign bus.id_valid = count != '0;
  assign bus.id_inst  = bus.id_valid ? inst_mem[head] : NOP_INST;
  assign bus.id_pc    = bus.id_valid ? pc_mem[head] : '0;
  // A flush while waiting only redirects to DROP; the response still has to be absorbed.
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = issue ? WAIT : IDLE;
    else if (state == WAIT) state_n = bus.imem_ack ? IDLE : (bus.br_ctrl ? DROP : WAIT);
    else state_n = bus.imem_ack ? IDLE : DROP;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      count         <= '0;
      head          <= '0;
      tail          <= '0;
      bus.imem_req  <= 1'b0;
      bus.imem_addr <= '0;
    end else begin
      state        <= state_n;
      bus.imem_req <= state_n != IDLE;
      if (issue) bus.imem_addr <= bus.pc_i;
      if (bus.br_ctrl) begin
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        count <= count + CW'(push) - CW'(pop);
        if (push) tail <= tail + AW'(1);
        if (pop) head <= head + AW'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]   <= bus.imem_addr;
      inst_mem[tail] <= bus.imem_rdata;
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: randomized fetch/flush/reset traffic scored against a queue-level reference model
module tb_ifetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;
  typedef struct packed {logic [31:0] pc; logic [31:0] inst;} ent_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] pc, target;
  int errors = 0, checks = 0;
  int ready_pct, ack_pct, br_pct, stray_pct, rst_pct;
  ent_t exp_q[$];
  ent_t e;
  bit busy = 0, doomed = 0, issue;
  logic [31:0] addr_m = '0;
  ifetch_queue_if bus();
  ifetch_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  assign bus.pc_i = pc;
  // Environment PC register: redirect on branch, step only when the fetcher is not stalling it.
  always @(posedge clk) begin
    if (!rst) pc <= '0;
    else if (bus.br_ctrl) pc <= target;
    else if (!bus.pc_stall) pc <= pc + 32'd4;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive();
    rst            = ($urandom_range(99) < rst_pct) ? 1'b0 : 1'b1;
    bus.id_ready   = $urandom_range(99) < ready_pct;
    bus.br_ctrl    = $urandom_range(99) < br_pct;
    target         = $urandom & 32'h0000_fffc;
    bus.imem_ack   = bus.imem_req ? ($urandom_range(99) < ack_pct) : ($urandom_range(99) < stray_pct);
    bus.imem_rdata = $urandom;
  endtask
  // Monitor/model: compare what the DUT presents, then apply this cycle's inputs to the model.
  always @(negedge clk) begin
    issue = rst && !busy && !bus.br_ctrl && exp_q.size() < DEPTH;
    check("id_valid", 32'(bus.id_valid), 32'(exp_q.size() != 0));
    check("pc_stall", 32'(bus.pc_stall), 32'(busy || exp_q.size() == DEPTH));
    check("imem_req", 32'(bus.imem_req), 32'(busy));
    check("imem_addr", bus.imem_addr, addr_m);
    if (exp_q.size() == 0) begin
      check("id_inst_empty", bus.id_inst, NOP);
      check("id_pc_empty", bus.id_pc, 32'h0);
    end else if (bus.id_ready && rst) begin
      e = exp_q.pop_front();
      check("id_pc", bus.id_pc, e.pc);
      check("id_inst", bus.id_inst, e.inst);
    end
    if (!rst) begin
      exp_q.delete();
      busy   = 0;
      doomed = 0;
      addr_m = '0;
    end else begin
      if (busy && bus.imem_ack) begin
        if (!bus.br_ctrl && !doomed) exp_q.push_back({addr_m, bus.imem_rdata});
        busy   = 0;
        doomed = 0;
      end else if (busy && bus.br_ctrl) doomed = 1;
      if (bus.br_ctrl) exp_q.delete();
      if (issue) begin
        busy   = 1;
        addr_m = bus.pc_i;
      end
    end
  end
  initial begin
    bus.br_ctrl = 0; bus.id_ready = 0; bus.imem_ack = 0; bus.imem_rdata = '0; target = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    for (int p = 0; p < 40; p++) begin
      case (p)
        0: begin ready_pct = 100; ack_pct = 100; br_pct = 0; stray_pct = 0; rst_pct = 0; end
        1: begin ready_pct = 0; ack_pct = 100; br_pct = 0; stray_pct = 0; rst_pct = 0; end
        2: begin ready_pct = 100; ack_pct = 30; br_pct = 10; stray_pct = 0; rst_pct = 0; end
        3: begin ready_pct = 50; ack_pct = 30; br_pct = 0; stray_pct = 40; rst_pct = 5; end
        default: begin
          ready_pct = ($urandom_range(3) == 0) ? 0 : (($urandom_range(1) == 0) ? 100 : 50);
          ack_pct   = ($urandom_range(1) == 0) ? 100 : 30;
          br_pct    = ($urandom_range(2) == 0) ? 0 : 6;
          stray_pct = ($urandom_range(1) == 0) ? 0 : 25;
          rst_pct   = ($urandom_range(3) == 0) ? 3 : 0;
        end
      endcase
      repeat (60) begin
        @(posedge clk);
        #2 drive();
      end
    end
    @(posedge clk);
    #2 rst = 1'b1; bus.br_ctrl = 0; bus.imem_ack = 0;
    repeat (2) @(posedge clk);
    #3 $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
